// File: rtl/lcd_st7920_bus_monitor.sv
// Responder-side monitor for the ST7920 8-bit parallel write bus.
// Decodes basic-instruction commands and mirrors panel text in a 64-byte shadow buffer.
module lcd_st7920_bus_monitor #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_dat,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       ext_mode,
    output logic       busy,
    output logic       overrun,
    output logic       wr_strobe
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

    // ptr is {ac[4:0],half}; the ST7920 interleaves rows 0/2 and 1/3 in DDRAM
    function automatic logic [5:0] buf_index(input logic [5:0] p);
        return {p[4], p[5], p[3:0]};
    endfunction

    logic [10:0] sync_p [SS];
    logic        en_prev_p;
    logic        en_s;
    logic        rs_s;
    logic        rw_s;
    logic [7:0]  dat_s;
    logic        fall;
    logic        xfer;
    logic        accept;
    logic        data_wr;
    logic        instr;

    logic [5:0]  ptr_q;
    logic [5:0]  ptr_d;
    logic        inc_q;
    logic        inc_d;
    logic        ext_d;
    logic        disp_d;
    logic        cursor_d;
    logic        blink_d;
    logic        clear_start;

    fill_state_t state_q;
    fill_state_t state_d;
    logic [5:0]  fill_cnt;
    logic        fill_we;

    logic [7:0]  shadow_mem [64];

    // Bus synchronizers: every bus bit travels through the same number of flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SS; i++) begin
                sync_p[i] <= '0;
            end
            en_prev_p <= 1'b0;
        end else begin
            sync_p[0] <= {lcd_en, lcd_rs, lcd_rw, lcd_dat};
            for (int i = 1; i < SS; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
            en_prev_p <= sync_p[SS-1][10];
        end
    end

    assign en_s    = sync_p[SS-1][10];
    assign rs_s    = sync_p[SS-1][9];
    assign rw_s    = sync_p[SS-1][8];
    assign dat_s   = sync_p[SS-1][7:0];
    assign fall    = en_prev_p & ~en_s;
    assign xfer    = fall & ~rw_s;
    assign accept  = xfer & ~busy;
    assign data_wr = accept & rs_s;
    assign instr   = accept & ~rs_s;

    always_comb begin
        ptr_d       = ptr_q;
        inc_d       = inc_q;
        ext_d       = ext_mode;
        disp_d      = disp_on;
        cursor_d    = cursor_on;
        blink_d     = blink_on;
        clear_start = 1'b0;
        if (data_wr) begin
            ptr_d = inc_q ? ptr_q + 6'd1 : ptr_q - 6'd1;
        end else if (instr) begin
            if (dat_s[7:5] == 3'b001) begin
                ext_d = dat_s[2];
            end else if (!ext_mode) begin
                if (dat_s[7]) begin
                    if (dat_s[6:5] == 2'b00) begin
                        ptr_d = {dat_s[4:0], 1'b0};
                    end
                end else if (dat_s[7:3] == 5'b00001) begin
                    {disp_d, cursor_d, blink_d} = dat_s[2:0];
                end else if (dat_s[7:2] == 6'b000001) begin
                    inc_d = dat_s[1];
                end else if (dat_s[7:1] == 7'b0000001) begin
                    ptr_d = 6'd0;
                end else if (dat_s == 8'h01) begin
                    ptr_d       = 6'd0;
                    inc_d       = 1'b1;
                    clear_start = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= 6'd0;
            inc_q     <= 1'b1;
            ext_mode  <= 1'b0;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            overrun   <= 1'b0;
            wr_strobe <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            inc_q     <= inc_d;
            ext_mode  <= ext_d;
            disp_on   <= disp_d;
            cursor_on <= cursor_d;
            blink_on  <= blink_d;
            overrun   <= overrun | (xfer & busy);
            wr_strobe <= data_wr;
        end
    end

    // Clear fill FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            fill_cnt <= 6'd0;
        end else begin
            state_q  <= state_d;
            fill_cnt <= (state_q == ST_FILL) ? fill_cnt + 6'd1 : 6'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (clear_start) state_d = ST_FILL;
            ST_FILL: if (fill_cnt == 6'd63) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        fill_we = 1'b0;
        if (state_q == ST_FILL) begin
            busy    = 1'b1;
            fill_we = 1'b1;
        end
    end

    // Shadow buffer; data_wr is already gated off while the fill owns the port
    always_ff @(posedge clk) begin
        if (fill_we) begin
            shadow_mem[fill_cnt] <= CLEAR_CHAR;
        end else if (data_wr) begin
            shadow_mem[buf_index(ptr_q)] <= dat_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= shadow_mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_lcd_st7920_bus_monitor.sv
// Bench for lcd_st7920_bus_monitor: vector table, directed corner cases and
// randomized transfers scored against a behavioural model of the panel.
module tb_lcd_st7920_bus_monitor;

    logic       clk;
    logic       rst_n;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_dat;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       disp_on;
    logic       cursor_on;
    logic       blink_on;
    logic       ext_mode;
    logic       busy;
    logic       overrun;
    logic       wr_strobe;

    lcd_st7920_bus_monitor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_dat   (lcd_dat),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .disp_on   (disp_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .ext_mode  (ext_mode),
        .busy      (busy),
        .overrun   (overrun),
        .wr_strobe (wr_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt++;
        if (busy) busy_cnt++;
    end

    // Behavioural model of the panel state
    logic [7:0] m_buf [64];
    bit         m_def [64];
    int         m_ptr;
    bit         m_inc, m_ext, m_disp, m_cur, m_blink;

    function automatic int m_index(input int p);
        int ac, half, row, col;
        ac   = p / 2;
        half = p % 2;
        row  = ((ac / 8) % 2) * 2 + ((ac / 16) % 2);
        col  = (ac % 8) * 2 + half;
        return row * 16 + col;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 64; i++) begin
            m_buf[i] = 8'h20;
            m_def[i] = 1'b1;
        end
        m_ptr = 0;
        m_inc = 1'b1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_def[i] = 1'b0;
        m_ptr = 0; m_inc = 1'b1; m_ext = 1'b0;
        m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0;
    endtask

    task automatic m_apply(input bit rs, input bit rw, input int d, output bit clr);
        clr = 1'b0;
        if (rw) return;
        if (rs) begin
            m_buf[m_index(m_ptr)] = d[7:0];
            m_def[m_index(m_ptr)] = 1'b1;
            m_ptr = m_inc ? (m_ptr + 1) % 64 : (m_ptr + 63) % 64;
        end else if (d >= 32 && d < 64) begin
            m_ext = ((d / 4) % 2) == 1;
        end else if (!m_ext) begin
            if (d >= 128) begin
                if (((d / 32) % 4) == 0) m_ptr = (d % 32) * 2;
            end else if (d >= 64 || d >= 16) begin
                // CGRAM address and shift commands leave the model untouched
            end else if (d >= 8) begin
                m_disp = ((d / 4) % 2) == 1;
                m_cur = ((d / 2) % 2) == 1;
                m_blink = (d % 2) == 1;
            end else if (d >= 4) begin
                m_inc = ((d / 2) % 2) == 1;
            end else if (d >= 2) begin
                m_ptr = 0;
            end else if (d == 1) begin
                m_clear();
                clr = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rs, input logic rw, input logic [7:0] d);
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = rw; lcd_dat = d; lcd_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 lcd_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: busy still %0d after %0d clk, expected 0", tag, busy, n);
        end
    endtask

    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
        bit clr;
        drive(rs, rw, d);
        m_apply(rs, rw, int'(d), clr);
        if (clr) wait_idle("clear_done");
    endtask

    task automatic read_buf(input logic [5:0] a, output logic [7:0] v);
        rd_addr = a;
        @(posedge clk); #1;
        v = rd_data;
    endtask

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] dat;
        logic [3:0] flags;
        logic       chk;
        logic [5:0] addr;
        logic [7:0] val;
    } vec_t;

    vec_t vecs [26];

    task automatic setv(input int i, input logic rs, input logic rw, input logic [7:0] d,
                        input logic [3:0] f, input logic c, input logic [5:0] a, input logic [7:0] v);
        vecs[i].rs = rs; vecs[i].rw = rw; vecs[i].dat = d; vecs[i].flags = f;
        vecs[i].chk = c; vecs[i].addr = a; vecs[i].val = v;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int s0, b0, r;
        logic [7:0] d;
        logic rs, rw;

        setv(0,  0, 0, 8'h90, 4'b0000, 0, 6'd0,  8'h00);
        setv(1,  1, 0, 8'h41, 4'b0000, 1, 6'd16, 8'h41);
        setv(2,  1, 0, 8'h42, 4'b0000, 1, 6'd17, 8'h42);
        setv(3,  0, 0, 8'h0C, 4'b1000, 1, 6'd18, 8'h20);
        setv(4,  0, 0, 8'h04, 4'b1000, 0, 6'd0,  8'h00);
        setv(5,  0, 0, 8'h80, 4'b1000, 0, 6'd0,  8'h00);
        setv(6,  1, 0, 8'h55, 4'b1000, 1, 6'd0,  8'h55);
        setv(7,  1, 0, 8'h66, 4'b1000, 1, 6'd63, 8'h66);
        setv(8,  1, 1, 8'h77, 4'b1000, 1, 6'd62, 8'h20);
        setv(9,  0, 0, 8'h06, 4'b1000, 0, 6'd0,  8'h00);
        setv(10, 0, 0, 8'h0F, 4'b1110, 0, 6'd0,  8'h00);
        setv(11, 0, 0, 8'h34, 4'b1111, 0, 6'd0,  8'h00);
        setv(12, 0, 0, 8'h08, 4'b1111, 0, 6'd0,  8'h00);
        setv(13, 0, 0, 8'h88, 4'b1111, 0, 6'd0,  8'h00);
        setv(14, 1, 0, 8'h99, 4'b1111, 1, 6'd62, 8'h99);
        setv(15, 0, 0, 8'h30, 4'b1110, 0, 6'd0,  8'h00);
        setv(16, 0, 0, 8'h88, 4'b1110, 0, 6'd0,  8'h00);
        setv(17, 1, 0, 8'hAB, 4'b1110, 1, 6'd32, 8'hAB);
        setv(18, 0, 0, 8'h02, 4'b1110, 0, 6'd0,  8'h00);
        setv(19, 1, 0, 8'hCD, 4'b1110, 1, 6'd0,  8'hCD);
        setv(20, 0, 0, 8'hA0, 4'b1110, 0, 6'd0,  8'h00);
        setv(21, 1, 0, 8'hEF, 4'b1110, 1, 6'd1,  8'hEF);
        setv(22, 0, 0, 8'h1C, 4'b1110, 0, 6'd0,  8'h00);
        setv(23, 1, 0, 8'h12, 4'b1110, 1, 6'd2,  8'h12);
        setv(24, 0, 0, 8'h00, 4'b1110, 0, 6'd0,  8'h00);
        setv(25, 1, 0, 8'h13, 4'b1110, 1, 6'd3,  8'h13);

        rst_n = 1'b0; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
        lcd_dat = 8'h00; rd_addr = 6'd0;
        m_reset();

        // T1 reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {rd_data, disp_on, cursor_on, blink_on, ext_mode, busy, overrun, wr_strobe}, 32'h0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_after_reset", {disp_on, cursor_on, blink_on, ext_mode, busy, overrun, wr_strobe}, 32'h0);

        // T2 clear: busy for exactly 64 clk, buffer filled
        b0 = busy_cnt;
        xfer(0, 0, 8'h01);
        repeat (20) @(posedge clk);
        #1;
        check("clear_busy_cycles", busy_cnt - b0, 64);
        for (int i = 0; i < 64; i++) begin
            read_buf(6'(i), v);
            check($sformatf("clear_fill[%0d]", i), v, 8'h20);
        end

        // Latency and same-cycle read-before-write on index 0
        rd_addr = 6'd0;
        @(posedge clk); #1;
        lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_dat = 8'h3C; lcd_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 lcd_en = 1'b0;
        @(posedge clk); #1;
        check("latency_p1_strobe", wr_strobe, 0);
        @(posedge clk); #1;
        check("latency_p2_strobe", wr_strobe, 0);
        @(posedge clk); #1;
        check("latency_p3_strobe", wr_strobe, 1);
        check("latency_p3_old_byte", rd_data, 8'h20);
        @(posedge clk); #1;
        check("latency_p4_strobe", wr_strobe, 0);
        check("latency_p4_new_byte", rd_data, 8'h3C);
        begin
            bit clr;
            m_apply(1, 0, 8'h3C, clr);
        end
        repeat (3) @(posedge clk);
        #1;

        // Vector table (T3, T5, T6 command decode)
        for (int i = 0; i < 26; i++) begin
            s0 = strobe_cnt;
            xfer(vecs[i].rs, vecs[i].rw, vecs[i].dat);
            check($sformatf("vec%0d_flags", i), {disp_on, cursor_on, blink_on, ext_mode}, vecs[i].flags);
            check($sformatf("vec%0d_strobes", i), strobe_cnt - s0, (vecs[i].rs && !vecs[i].rw) ? 1 : 0);
            if (vecs[i].chk) begin
                read_buf(vecs[i].addr, v);
                check($sformatf("vec%0d_buf[%0d]", i, vecs[i].addr), v, vecs[i].val);
            end
        end

        // T4 row 3 fill and wrap to index 0
        xfer(0, 0, 8'h98);
        for (int i = 0; i < 16; i++) xfer(1, 0, 8'h30 + 8'(i));
        xfer(1, 0, 8'h40);
        for (int i = 0; i < 16; i++) begin
            read_buf(6'(48 + i), v);
            check($sformatf("row3[%0d]", 48 + i), v, 8'h30 + 8'(i));
        end
        read_buf(6'd0, v);
        check("wrap_buf0", v, 8'h40);

        // Randomized transfers against the model
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 99);
            rs = 1'b0; rw = 1'b0;
            if (r < 45) begin
                rs = 1'b1; d = 8'($urandom_range(0, 255));
            end else if (r < 50) begin
                rw = 1'b1; rs = 1'($urandom_range(0, 1)); d = 8'($urandom_range(0, 255));
            end else if (r < 60) begin
                d = ($urandom_range(0, 1) == 1) ? 8'h80 | 8'($urandom_range(0, 31))
                                                : 8'h80 | 8'($urandom_range(0, 127));
            end else if (r < 66) begin
                d = 8'h20 | 8'($urandom_range(0, 31));
            end else if (r < 72) begin
                d = 8'h04 | 8'($urandom_range(0, 3));
            end else if (r < 80) begin
                d = 8'h08 | 8'($urandom_range(0, 7));
            end else if (r < 82) begin
                d = 8'h02 | 8'($urandom_range(0, 1));
            end else if (r < 84) begin
                d = 8'h01;
            end else begin
                d = 8'($urandom_range(0, 255));
            end
            s0 = strobe_cnt;
            xfer(rs, rw, d);
            check($sformatf("rand%0d_flags", n), {disp_on, cursor_on, blink_on, ext_mode},
                  {m_disp, m_cur, m_blink, m_ext});
            check($sformatf("rand%0d_strobes", n), strobe_cnt - s0, (rs && !rw) ? 1 : 0);
        end
        for (int i = 0; i < 64; i++) begin
            if (m_def[i]) begin
                read_buf(6'(i), v);
                check($sformatf("rand_buf[%0d]", i), v, m_buf[i]);
            end
        end
        check("no_overrun_yet", overrun, 0);

        // T6 transfer during clear is dropped and flags overrun; clear restores increment
        xfer(0, 0, 8'h30);
        xfer(0, 0, 8'h04);
        drive(0, 0, 8'h01);
        m_clear();
        check("busy_during_clear", busy, 1);
        drive(1, 0, 8'h11);
        check("overrun_set", overrun, 1);
        wait_idle("clear_after_overrun");
        read_buf(6'd0, v);
        check("dropped_byte", v, 8'h20);
        xfer(1, 0, 8'h5A);
        xfer(1, 0, 8'h5B);
        read_buf(6'd0, v);
        check("post_clear_buf0", v, 8'h5A);
        read_buf(6'd1, v);
        check("post_clear_inc_buf1", v, 8'h5B);
        check("overrun_sticky", overrun, 1);

        // Reset asserted mid-fill
        drive(0, 0, 8'h01);
        repeat (5) @(posedge clk);
        #1;
        check("midfill_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        check("midfill_reset_outputs",
              {rd_data, disp_on, cursor_on, blink_on, ext_mode, busy, overrun, wr_strobe}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("after_midfill_idle", {busy, overrun, wr_strobe}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
